// File: rtl/selector_pkg.sv
// Shared types and helpers for the N-channel round-robin selector.
package selector_pkg;

  typedef enum logic {
    SEL_FIXED = 1'b0,
    SEL_RR    = 1'b1
  } sel_mode_e;

  function automatic int sel_width(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/selector_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr.
module rr_arbiter
  import selector_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            grant_valid,
  output logic [SELW-1:0] grant_idx
);

  logic [N-1:0]    rot;
  logic [SELW-1:0] off;
  logic [SELW:0]   sum;

  always_comb begin
    // rot[i] is the request of channel (ptr + i) mod N
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
    grant_valid = |req;
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (SELW + 1)'(N)) sum = sum - (SELW + 1)'(N);
    grant_idx = sum[SELW-1:0];
  end

endmodule

// File: rtl/selector_rr_n.sv
// N-channel selector with registered output slot, valid/ready
// handshakes and fixed or round-robin channel selection.
module selector_rr_n
  import selector_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  localparam int SELW  = sel_width(N)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [N-1:0][WIDTH-1:0]   d,
  input  logic [N-1:0]              valid_in,
  output logic [N-1:0]              ready_in,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic [SELW-1:0]           y_ch
);

  sel_mode_e       md;
  logic [SELW-1:0] ptr;
  logic            rr_valid;
  logic [SELW-1:0] rr_idx;
  logic            fx_valid;
  logic            gnt_valid;
  logic [SELW-1:0] gnt;
  logic            load_ok;
  logic            xfer;

  assign md = sel_mode_e'(mode);

  rr_arbiter #(.N(N)) u_arb (
    .req         (valid_in),
    .ptr         (ptr),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

  always_comb begin
    // out-of-range sel simply never grants
    fx_valid = 1'b0;
    if (int'(sel) < N) fx_valid = valid_in[sel];
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    unique case (md)
      SEL_FIXED: begin
        gnt_valid = fx_valid;
        gnt       = sel;
      end
      SEL_RR: begin
        gnt_valid = rr_valid;
        gnt       = rr_idx;
      end
      default: ;
    endcase
  end

  assign load_ok = !y_valid || y_ready;

  always_comb begin
    ready_in = '0;
    if (!reset && load_ok && gnt_valid) ready_in[gnt] = 1'b1;
  end

  assign xfer = |ready_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_ch    <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      y       <= d[gnt];
      y_ch    <= gnt;
      y_valid <= 1'b1;
      if (md == SEL_RR) begin
        ptr <= (gnt == SELW'(N - 1)) ? '0 : gnt + 1'b1;
      end
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_selector_rr_n.sv
// Self-checking bench for selector_rr_n: directed plan plus random
// traffic against a behavioural slot/pointer model.
module tb_selector_rr_n;

  localparam int N     = 4;
  localparam int WIDTH = 4;
  localparam int SELW  = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    mode;
  logic [SELW-1:0]         sel;
  logic [N-1:0][WIDTH-1:0] d;
  logic [N-1:0]            valid_in;
  logic [N-1:0]            ready_in;
  logic [WIDTH-1:0]        y;
  logic                    y_valid;
  logic                    y_ready;
  logic [SELW-1:0]         y_ch;

  int n_assert = 0;
  int n_fail   = 0;

  int m_y, m_valid, m_ch, m_ptr;

  selector_rr_n #(.WIDTH(WIDTH), .N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .sel      (sel),
    .d        (d),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_ch     (y_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (mode == 1'b0) begin
      if (int'(sel) < N && valid_in[sel]) return int'(sel);
      return -1;
    end
    for (int off = 0; off < N; off++) begin
      if (valid_in[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
    return -1;
  endfunction

  // Called at negedge with inputs already driven; returns at next negedge.
  task automatic step(string tag);
    int g;
    logic [N-1:0] er;
    #1;
    g  = model_grant();
    er = '0;
    if (!reset && (m_valid == 0 || y_ready) && g >= 0) er[g] = 1'b1;
    chk({tag, ".ready_in"}, 32'(ready_in), 32'(er));
    @(posedge clk);
    if (reset) begin
      m_y = 0; m_valid = 0; m_ch = 0; m_ptr = 0;
    end else if (er != '0) begin
      m_y = int'(d[g]); m_ch = g; m_valid = 1;
      if (mode) m_ptr = (g + 1) % N;
    end else if (m_valid != 0 && y_ready) begin
      m_valid = 0;
    end
    #1;
    chk({tag, ".y"},       32'(y),       32'(m_y));
    chk({tag, ".y_valid"}, 32'(y_valid), 32'(m_valid));
    chk({tag, ".y_ch"},    32'(y_ch),    32'(m_ch));
    chk({tag, ".ptr"},     32'(dut.ptr), 32'(m_ptr));
    @(negedge clk);
  endtask

  initial begin
    m_y = 0; m_valid = 0; m_ch = 0; m_ptr = 0;
    reset = 1'b1; mode = 1'b1; sel = '0; y_ready = 1'b1;
    valid_in = 4'b1111;
    for (int k = 0; k < N; k++) d[k] = WIDTH'(k + 5);
    @(negedge clk);

    // reset held two cycles
    step("rst0");
    step("rst1");
    chk("rst.ready_in", 32'(ready_in), 32'h0);
    chk("rst.y", 32'(y), 32'h0);
    chk("rst.y_valid", 32'(y_valid), 32'h0);
    reset = 1'b0;
    step("rst_rel");
    chk("rst_rel.first_ch", 32'(y_ch), 32'h0);

    // fixed select
    reset = 1'b1; step("fx_rst"); reset = 1'b0;
    mode = 1'b0; sel = 2'd2; valid_in = 4'b0100; d[2] = 4'hA;
    #1 chk("fx.ready_lit", 32'(ready_in), 32'b0100);
    step("fx");
    chk("fx.y_lit", 32'(y), 32'hA);
    chk("fx.ch_lit", 32'(y_ch), 32'h2);
    valid_in = 4'b1011;
    #1 chk("fx.noreq_lit", 32'(ready_in), 32'h0);
    step("fx_noreq");

    // round-robin fairness
    reset = 1'b1; step("rr_rst"); reset = 1'b0;
    mode = 1'b1; valid_in = 4'b1111;
    for (int k = 0; k < N; k++) d[k] = WIDTH'(k + 5);
    for (int i = 0; i < 5; i++) begin
      step("rr");
      chk("rr.ch_lit", 32'(y_ch), 32'(i % 4));
      chk("rr.y_lit", 32'(y), 32'(i % 4 + 5));
      chk("rr.v_lit", 32'(y_valid), 32'h1);
    end

    // round-robin skip
    reset = 1'b1; step("sk_rst"); reset = 1'b0;
    valid_in = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step("skip");
      chk("skip.ch_lit", 32'(y_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
      chk("skip.ptr_lit", 32'(dut.ptr), (i % 2 == 0) ? 32'd2 : 32'd0);
    end

    // backpressure
    reset = 1'b1; step("bp_rst"); reset = 1'b0;
    valid_in = 4'b1111;
    for (int k = 0; k < N; k++) d[k] = WIDTH'(k + 3);
    step("bp_load");
    chk("bp.y_lit", 32'(y), 32'h3);
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("bp_stall");
      chk("bp.stall_y_lit", 32'(y), 32'h3);
      chk("bp.stall_ch_lit", 32'(y_ch), 32'h0);
    end
    #1 chk("bp.stall_ready_lit", 32'(ready_in), 32'h0);
    y_ready = 1'b1;
    #1 chk("bp.resume_ready_lit", 32'(ready_in), 32'b0010);
    step("bp_resume");
    chk("bp.resume_y_lit", 32'(y), 32'h4);
    chk("bp.resume_v_lit", 32'(y_valid), 32'h1);

    // reset during stall with ptr = 2
    reset = 1'b1; step("ms_rst0"); reset = 1'b0;
    valid_in = 4'b0010;
    step("ms_load");
    y_ready = 1'b0; valid_in = 4'b1111;
    step("ms_stall");
    chk("ms.ptr_lit", 32'(dut.ptr), 32'h2);
    reset = 1'b1;
    step("ms_rst");
    chk("ms.v_lit", 32'(y_valid), 32'h0);
    chk("ms.y_lit", 32'(y), 32'h0);
    chk("ms.ptr0_lit", 32'(dut.ptr), 32'h0);
    reset = 1'b0; y_ready = 1'b1;
    step("ms_after");
    chk("ms.grant0_lit", 32'(y_ch), 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 31) == 0);
      mode     = 1'($urandom);
      sel      = SELW'($urandom);
      valid_in = N'($urandom);
      y_ready  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) d[k] = WIDTH'($urandom);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
